// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_arbiter_if
//  Description : Writeback request, scoreboard and register-file write bundle
//                shared between the execute/memory stages, decode and the
//                register-file writeback arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_wb_arbiter_if;
    // Port 0: ALU writeback
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    // Port 1: load-data writeback
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    // Decode issue and hazard query
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addrA;
    logic [4:0]  chk_addrB;
    logic        busyA;
    logic        busyB;
    // Register-file write port
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  issue_valid, issue_addr, chk_addrA, chk_addrB,
        output busyA, busyB,
        output wr_en, wr_addr, wr_data
    );

    // Requester / decode / register-file side
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output issue_valid, issue_addr, chk_addrA, chk_addrB,
        input  busyA, busyB,
        input  wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_arbiter
//  Description : Two-port writeback arbiter for the 32x32 register file with a
//                registered write stage and a per-register busy scoreboard.
//                Port 0 = ALU result, port 1 = load data.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_wb_arbiter #(
    parameter int RR_EN   = 1,  // 1 = round-robin, 0 = fixed priority
    parameter int FIX_PRI = 1   // favoured port when RR_EN = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,   // synchronous, active-low
    reg_wb_arbiter_if.slave   bus
);

    logic        rr_ptr_q, rr_ptr_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] busy_q, busy_d;

    logic        w_pick;   // port that wins when both are valid
    logic        w_gnt0;
    logic        w_gnt1;

    // Contention winner: pointer in round-robin mode, fixed port otherwise
    generate
        if (RR_EN != 0) begin : g_rr
            assign w_pick = rr_ptr_q;
        end else begin : g_fix
            assign w_pick = (FIX_PRI != 0);
        end
    endgenerate

    // Grants are combinational and suppressed while reset is asserted
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            w_gnt0 = bus.req0_valid && (!bus.req1_valid || (w_pick == 1'b0));
            w_gnt1 = bus.req1_valid && (!bus.req0_valid || (w_pick == 1'b1));
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    // Next-state for pointer, write stage and scoreboard
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;

        // After any transfer the other port becomes favoured
        if (w_gnt0) begin
            rr_ptr_d  = 1'b1;
            wr_addr_d = bus.req0_addr;
            wr_data_d = bus.req0_data;
            wr_en_d   = (bus.req0_addr != 5'd0);  // r0 writes are swallowed
        end else if (w_gnt1) begin
            rr_ptr_d  = 1'b0;
            wr_addr_d = bus.req1_addr;
            wr_data_d = bus.req1_data;
            wr_en_d   = (bus.req1_addr != 5'd0);
        end

        // Clear on commit first so a same-edge issue to that register wins
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_addr != 5'd0)) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            busy_q    <= 32'd0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    // Hazard lookups have no bypass of in-flight data
    assign bus.busyA = busy_q[bus.chk_addrA];
    assign bus.busyB = busy_q[bus.chk_addrB];

endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Controls the single write port of the 32x32 register file. Two writeback requesters share it: port 0 is the ALU result and port 1 is the load-data return.
- Arbitrates between them with round-robin or fixed priority and registers the winning write onto the file's write-enable/address/data inputs.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority.
- FIX_PRI, 1, favoured port index when RR_EN=0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge
- req0_valid  in  1  ALU writeback request
- req0_addr  in  5  ALU destination register
- req0_data  in  32  ALU result
- req0_ready  out  1  port 0 accepted this cycle
- req1_valid  in  1  load writeback request
- req1_addr  in  5  load destination register
- req1_data  in  32  load data
- req1_ready  out  1  port 1 accepted this cycle
- issue_valid  in  1  decode issued an instruction with a destination
- issue_addr  in  5  destination of the issued instruction
- chk_addrA  in  5  source A being decoded
- chk_addrB  in  5  source B being decoded
- busyA  out  1  source A has an outstanding writer
- busyB  out  1  source B has an outstanding writer
- wr_en  out  1  to register file WriteReg
- wr_addr  out  5  to register file addrW
- wr_data  out  32  to register file dataW

Behaviour:
- Reset (rst=0 at a clk edge): wr_en=0, wr_addr=0, wr_data=0, busy[31:0]=0, rr_ptr=0 (port 0 favoured). The ready outputs are combinational and are forced to 0 while rst=0.
- Handshake: a transfer occurs on port n when reqn_valid and reqn_ready are both 1 at a clk edge. reqn_ready is combinational from the valids and the pointer. At most one ready is high per cycle. A requester holds valid, addr and data stable until it sees ready.
- Arbitration with one valid: that port gets ready.
- Arbitration with both valid, RR_EN=1: the port equal to rr_ptr wins. After every transfer, rr_ptr becomes the other port index, even if the transfer was uncontended.
- Arbitration with both valid, RR_EN=0: port FIX_PRI always wins and rr_ptr is unused.
- Write latency: one cycle. A transfer at edge k sets wr_en=1 with the captured addr/data for the cycle after edge k, so the register file writes at edge k+1. With no transfer, wr_en=0 next cycle and wr_addr/wr_data hold their values.
- Address 0: a request is still accepted (ready=1), but wr_en stays 0. This port never writes r0.
- Throughput: one write per cycle sustained. Back-to-back transfers produce consecutive wr_en cycles.
- Scoreboard set: issue_valid=1 with issue_addr≠0 sets busy[issue_addr] at the edge.
- Scoreboard clear: at an edge where wr_en=1, busy[wr_addr] clears. This is the same edge at which the register file commits, so the register value is valid in the cycle busy drops.
- Simultaneous set and clear of the same register at one edge: set wins and busy stays 1, since a new producer is in flight.
- busy[0] is constant 0.
- Hazard outputs: busyA = busy[chk_addrA], busyB = busy[chk_addrB], both combinational. No bypass of in-flight data.
- Mid-operation reset: pending wr_en is dropped (cleared), all busy bits clear and rr_ptr returns to 0. Requests presented during reset are not accepted.
- Multiple outstanding issues to one register: a single bit is kept, so the first write clears it. Decode must not issue a second writer to a busy register; this is a decode-side rule and is not checked here.

Test Plan:
- Reset: hold rst=0 for 2 edges with both valids high -> ready0=ready1=0, wr_en=0, busyA=busyB=0. Release rst -> port 0 wins first.
- Single write: req0 addr=5, data=0xDEADBEEF for 1 cycle -> ready0=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- Round-robin: both valid continuously, addr0=3, addr1=4, RR_EN=1 -> grants alternate 0,1,0,1. wr_addr sequence is 3,4,3,4 on consecutive cycles.
- Fixed priority: RR_EN=0, FIX_PRI=1, both valid -> ready1 on every cycle and ready0 never, until req1_valid drops.
- r0 discard: req1 addr=0, data=0x1234 -> ready1=1 and no wr_en pulse. issue_addr=0 -> chk_addrA=0 gives busyA=0.
- Scoreboard: issue r7, then chk_addrA=7 -> busyA=1. req0 write to r7 -> busyA=1 through the wr_en cycle and 0 the cycle after. Then issue r7 and wr_en to r7 on the same edge -> busyA stays 1.
